// File: rtl/twiddle_generator.sv
// Twiddle sequencer for one radix-2 DIT FFT stage: emits W^k words in Q8.8
// ({real, imag}) over a valid/ready port, with an inverse (conjugate) mode.
module twiddle_generator #(
  parameter int N     = 8,
  parameter int LOG2N = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LOG2N-1:0] stage,
  input  logic             inverse,
  output logic [31:0]      tw_out,
  output logic [LOG2N-2:0] tw_index,
  output logic             tw_valid,
  input  logic             tw_ready,
  output logic             tw_last,
  output logic             busy,
  output logic             done,
  output logic             err
);

  // Handshake: a word transfers on a rising edge where tw_valid && tw_ready;
  // tw_out/tw_index/tw_last hold stable while tw_valid && !tw_ready.

  localparam int          BW      = LOG2N - 1;
  localparam logic [0:0]  IDLE    = 1'b0;
  localparam logic [0:0]  RUN     = 1'b1;
  localparam longint      ONE_Q28 = 64'sd268435456;
  localparam longint      PI_Q28  = 64'sd843314857;

  // Taylor series in Q28 fixed point, then rounded half away from zero to Q8.8.
  function automatic longint trig_q88(input int k, input bit want_sin);
    longint x, term, sum;
    x = (2 * PI_Q28 * longint'(k)) / longint'(N);
    if (want_sin) begin
      term = x;
      sum  = x;
    end else begin
      term = ONE_Q28;
      sum  = ONE_Q28;
    end
    for (int i = 1; i <= 14; i++) begin
      term = (term * x) >>> 28;
      term = (term * x) >>> 28;
      if (want_sin) term = -term / longint'((2 * i) * (2 * i + 1));
      else          term = -term / longint'((2 * i - 1) * (2 * i));
      sum = sum + term;
    end
    if (sum >= 0) return (sum + 64'sd524288) >>> 20;
    else          return -((-sum + 64'sd524288) >>> 20);
  endfunction

  logic [15:0] cos_rom [N/2];
  logic [15:0] sin_rom [N/2];

  for (genvar g = 0; g < N/2; g++) begin : g_rom
    localparam logic [15:0] COS_V = 16'(trig_q88(g, 1'b0));
    localparam logic [15:0] SIN_V = 16'(trig_q88(g, 1'b1));
    assign cos_rom[g] = COS_V;
    assign sin_rom[g] = SIN_V;
  end

  logic [0:0]       state;
  logic [BW-1:0]    b;
  logic [LOG2N-1:0] s_reg;
  logic             inv_reg;

  logic [BW-1:0]    b_nxt;
  logic [BW-1:0]    mask;
  logic [BW-1:0]    k_nxt;
  logic [LOG2N-1:0] shamt;
  logic [15:0]      sin_v;
  logic [31:0]      word_nxt;
  logic             last_nxt;
  logic             xfer;

  // Next word is prepared from b+1 so it loads on the same edge as a transfer.
  always_comb begin
    b_nxt = b + BW'(1);
    mask  = '0;
    for (int i = 0; i < BW; i++) mask[i] = (i < int'(s_reg));
    shamt    = LOG2N'(BW) - s_reg;
    k_nxt    = (b_nxt & mask) << shamt;
    sin_v    = sin_rom[k_nxt];
    word_nxt = {cos_rom[k_nxt], inv_reg ? sin_v : -sin_v};
    last_nxt = (b_nxt == BW'(N/2 - 1));
  end

  assign xfer = tw_valid && tw_ready;
  assign busy = (state == RUN);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      b        <= '0;
      s_reg    <= '0;
      inv_reg  <= 1'b0;
      tw_out   <= '0;
      tw_index <= '0;
      tw_valid <= 1'b0;
      tw_last  <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          if (stage < LOG2N'(LOG2N)) begin
            state    <= RUN;
            b        <= '0;
            s_reg    <= stage;
            inv_reg  <= inverse;
            tw_valid <= 1'b1;
            // b = 0 always maps to k = 0, where the imaginary part is zero.
            tw_out   <= {cos_rom[0], 16'h0000};
            tw_index <= '0;
            tw_last  <= 1'b0;
          end else begin
            err <= 1'b1;
          end
        end
      end else if (xfer) begin
        if (tw_last) begin
          state    <= IDLE;
          tw_valid <= 1'b0;
          tw_out   <= '0;
          tw_index <= '0;
          tw_last  <= 1'b0;
          done     <= 1'b1;
        end else begin
          b        <= b_nxt;
          tw_out   <= word_nxt;
          tw_index <= k_nxt;
          tw_last  <= last_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_twiddle_generator.sv
// Bench for twiddle_generator: directed stage sequences plus randomized ready,
// stage and stray starts, scored against a real-arithmetic twiddle model.
module tb_twiddle_generator;

  localparam int N     = 8;
  localparam int LOG2N = 3;
  localparam int EW    = (LOG2N - 1) + 1 + 32;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [LOG2N-1:0] stage;
  logic             inverse;
  logic [31:0]      tw_out;
  logic [LOG2N-2:0] tw_index;
  logic             tw_valid;
  logic             tw_ready;
  logic             tw_last;
  logic             busy;
  logic             done;
  logic             err;

  twiddle_generator #(.N(N), .LOG2N(LOG2N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stage(stage), .inverse(inverse),
    .tw_out(tw_out), .tw_index(tw_index), .tw_valid(tw_valid), .tw_ready(tw_ready),
    .tw_last(tw_last), .busy(busy), .done(done), .err(err)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cnt;

  logic [EW-1:0] exp_q[$];
  logic          done_exp   = 1'b0;
  logic          err_exp    = 1'b0;
  logic          stall_pend = 1'b0;
  logic [EW-1:0] stall_word;

  logic [31:0] t_fwd [4] = '{32'h01000000, 32'h00B5FF4B, 32'h0000FF00, 32'hFF4BFF4B};
  logic [31:0] t_inv [4] = '{32'h01000000, 32'h00B500B5, 32'h00000100, 32'hFF4B00B5};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model
  function automatic int round_away(input real v);
    if (v >= 0.0) return int'($floor(v + 0.5));
    else          return -int'($floor(-v + 0.5));
  endfunction

  function automatic logic [31:0] model_word(input int k, input bit inv);
    real ang;
    int  re, im;
    ang = 2.0 * 3.141592653589793 * real'(k) / real'(N);
    re  = round_away($cos(ang) * 256.0);
    im  = round_away($sin(ang) * 256.0);
    if (!inv) im = -im;
    return {re[15:0], im[15:0]};
  endfunction

  task automatic push_stage(input int s, input bit inv);
    int k;
    for (int bb = 0; bb < N/2; bb++) begin
      k = (bb % (1 << s)) * ((N/2) >> s);
      exp_q.push_back({k[LOG2N-2:0], (bb == N/2 - 1), model_word(k, inv)});
    end
  endtask

  // Scoreboard / monitor, sampled on the falling edge
  always @(negedge clk) begin
    logic [EW-1:0] obs;
    logic [EW-1:0] e;
    if (!rst_n) begin
      stall_pend = 1'b0;
      done_exp   = 1'b0;
    end else begin
      obs = {tw_index, tw_last, tw_out};
      check("done", done, done_exp);
      check("err", err, err_exp);
      check("busy", busy, tw_valid);
      done_exp = 1'b0;
      if (!tw_valid) check("out_zero", tw_out, 0);
      if (stall_pend) check("hold", {tw_valid, obs}, {1'b1, stall_word});
      stall_pend = 1'b0;
      if (tw_valid) begin
        if (tw_ready) begin
          if (exp_q.size() == 0) begin
            check("extra_word", obs, 0);
          end else begin
            e = exp_q.pop_front();
            check("word", obs, e);
            if (e[32]) done_exp = 1'b1;
          end
        end else begin
          stall_pend = 1'b1;
          stall_word = obs;
        end
      end
    end
  end

  // Driver tasks (inputs change 1 time unit after the rising edge)
  task automatic start_pulse(input int s, input bit inv);
    start   = 1'b1;
    stage   = LOG2N'(s);
    inverse = inv;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_stage(input int s, input bit inv, input bit rnd);
    int guard;
    push_stage(s, inv);
    if (rnd) tw_ready = 1'($urandom_range(0, 1));
    start_pulse(s, inv);
    guard = 0;
    while (exp_q.size() != 0 && guard < 400) begin
      if (rnd) begin
        tw_ready = ($urandom_range(0, 3) != 0);
        if (exp_q.size() > 2 && $urandom_range(0, 5) == 0) begin
          start   = 1'b1;
          stage   = LOG2N'($urandom_range(0, (1 << LOG2N) - 1));
          inverse = 1'($urandom_range(0, 1));
        end else begin
          start = 1'b0;
        end
      end
      @(posedge clk); #1;
      guard++;
    end
    start = 1'b0;
    if (guard >= 400) check("stage_timeout", 1, 0);
  endtask

  task automatic table_stage(input bit inv);
    logic [31:0] w;
    push_stage(2, inv);
    start_pulse(2, inv);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      w = inv ? t_inv[i] : t_fwd[i];
      check(inv ? "tbl_inv" : "tbl_fwd", {tw_valid, tw_index, tw_last, tw_out},
            {1'b1, (LOG2N-1)'(i), (i == 3), w});
    end
    @(negedge clk);
    check("tbl_done", {done, tw_valid, busy}, 3'b100);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stage = '0; inverse = 1'b0; tw_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outs", {tw_valid, busy, done, err, tw_last, tw_index, tw_out}, 0);
    @(posedge clk); #1;
    rst_n    = 1'b1;
    tw_ready = 1'b1;
    @(posedge clk); #1;

    // Known sequences, stage 2 forward and inverse; stages 1 and 0 via model
    table_stage(1'b0);
    table_stage(1'b1);
    run_stage(1, 1'b0, 1'b0);
    run_stage(0, 1'b0, 1'b0);
    run_stage(0, 1'b1, 1'b0);

    // Backpressure on word 2 for 3 cycles
    push_stage(2, 1'b0);
    start_pulse(2, 1'b0);
    fork
      begin
        repeat (2) @(posedge clk);
        #1 tw_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("bp_hold", {tw_valid, tw_out}, {1'b1, 32'h0000FF00});
        end
        @(posedge clk);
        #1 tw_ready = 1'b1;
      end
      begin
        cnt = 0;
        do begin
          @(negedge clk);
          cnt++;
        end while (!done && cnt < 40);
      end
    join
    check("bp_done_cycle", cnt, 8);
    @(posedge clk); #1;

    // Out-of-range stage from IDLE
    start_pulse(3, 1'b0);
    err_exp = 1'b1;
    @(negedge clk);
    check("err_stays_idle", {busy, tw_valid}, 0);
    @(posedge clk); #1;
    err_exp = 1'b0;
    start_pulse(7, 1'b1);
    err_exp = 1'b1;
    @(posedge clk); #1;
    err_exp = 1'b0;

    // Reset after the first word of stage 2
    push_stage(2, 1'b0);
    start_pulse(2, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    check("midreset_outs", {tw_valid, busy, done, err, tw_last, tw_index, tw_out}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    run_stage(2, 1'b0, 1'b0);

    // Randomized stages, ready and stray starts
    for (int it = 0; it < 30; it++)
      run_stage($urandom_range(0, LOG2N - 1), 1'($urandom_range(0, 1)), 1'b1);

    tw_ready = 1'b1;
    repeat (4) @(posedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
